// File: rtl/decode.sv
// Decode stage: IF/ID register, RV32I field and immediate decode, ID/EX register,
// and load-use hazard detection that raises a single-cycle stall toward fetch.
module decode #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] inst,
    input  logic [width-1:0] pc,
    input  logic             flush,
    output logic             delay,
    output logic             d_valid,
    output logic [width-1:0] d_pc,
    output logic [4:0]       d_rs1,
    output logic [4:0]       d_rs2,
    output logic [4:0]       d_rd,
    output logic [width-1:0] d_imm,
    output logic [6:0]       d_opcode,
    output logic [2:0]       d_funct3,
    output logic             d_funct7b5,
    output logic             d_regwrite,
    output logic             d_memread,
    output logic             d_memwrite,
    output logic             d_branch,
    output logic             d_jump,
    output logic             d_illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [width-1:0] NOP = width'(32'h00000013);

    // IF/ID stage
    logic [width-1:0] if_inst_q, if_pc_q;
    logic             if_valid_q;

    // Decoded fields of the instruction currently in IF/ID
    logic [6:0]       dec_opcode;
    logic [4:0]       dec_rs1, dec_rs2, dec_rd;
    logic [width-1:0] dec_imm;
    logic             dec_regwrite, dec_memread, dec_memwrite, dec_branch, dec_jump;
    logic             dec_illegal, dec_rs1_used, dec_rs2_used;

    assign dec_opcode = if_inst_q[6:0];
    assign dec_rs1    = if_inst_q[19:15];
    assign dec_rs2    = if_inst_q[24:20];
    assign dec_rd     = if_inst_q[11:7];

    // Opcode-driven immediate, controls and source-register usage
    always_comb begin
        dec_imm      = '0;
        dec_regwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_branch   = 1'b0;
        dec_jump     = 1'b0;
        dec_illegal  = 1'b0;
        dec_rs1_used = 1'b0;
        dec_rs2_used = 1'b0;
        unique case (dec_opcode)
            OP_LOAD: begin
                dec_imm      = {{(width-12){if_inst_q[31]}}, if_inst_q[31:20]};
                dec_regwrite = 1'b1;
                dec_memread  = 1'b1;
                dec_rs1_used = 1'b1;
            end
            OP_IMM: begin
                dec_imm      = {{(width-12){if_inst_q[31]}}, if_inst_q[31:20]};
                dec_regwrite = 1'b1;
                dec_rs1_used = 1'b1;
            end
            OP_JALR: begin
                dec_imm      = {{(width-12){if_inst_q[31]}}, if_inst_q[31:20]};
                dec_regwrite = 1'b1;
                dec_jump     = 1'b1;
                dec_rs1_used = 1'b1;
            end
            OP_STORE: begin
                dec_imm      = {{(width-12){if_inst_q[31]}}, if_inst_q[31:25], if_inst_q[11:7]};
                dec_memwrite = 1'b1;
                dec_rs1_used = 1'b1;
                dec_rs2_used = 1'b1;
            end
            OP_BRANCH: begin
                dec_imm      = {{(width-13){if_inst_q[31]}}, if_inst_q[31], if_inst_q[7],
                                if_inst_q[30:25], if_inst_q[11:8], 1'b0};
                dec_branch   = 1'b1;
                dec_rs1_used = 1'b1;
                dec_rs2_used = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec_imm      = {if_inst_q[width-1:12], 12'b0};
                dec_regwrite = 1'b1;
            end
            OP_JAL: begin
                dec_imm      = {{(width-21){if_inst_q[31]}}, if_inst_q[31], if_inst_q[19:12],
                                if_inst_q[20], if_inst_q[30:21], 1'b0};
                dec_regwrite = 1'b1;
                dec_jump     = 1'b1;
            end
            OP_OP: begin
                dec_regwrite = 1'b1;
                dec_rs1_used = 1'b1;
                dec_rs2_used = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        // Writes to x0 are architecturally discarded, so never request them.
        if (dec_rd == 5'd0) dec_regwrite = 1'b0;
    end

    // Load-use hazard: the load in ID/EX produces a register the IF/ID instruction reads.
    // Reset and flush dominate so a squashed or reset pipeline never stalls fetch.
    always_comb begin
        delay = 1'b0;
        if (!rst && !flush && if_valid_q && d_valid && d_memread && (d_rd != 5'd0)) begin
            delay = (dec_rs1_used && (dec_rs1 == d_rd)) ||
                    (dec_rs2_used && (dec_rs2 == d_rd));
        end
    end

    // IF/ID register: reset/flush load a nop, stall holds, otherwise capture fetch
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            if_inst_q  <= NOP;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
        end else if (!delay) begin
            if_inst_q  <= inst;
            if_pc_q    <= pc;
            if_valid_q <= 1'b1;
        end
    end

    // ID/EX register: bubble on reset/flush/stall, otherwise capture the decode
    always_ff @(posedge clk) begin
        if (rst || flush || delay) begin
            d_valid    <= 1'b0;
            d_pc       <= '0;
            d_rs1      <= '0;
            d_rs2      <= '0;
            d_rd       <= '0;
            d_imm      <= '0;
            d_opcode   <= OP_IMM;
            d_funct3   <= '0;
            d_funct7b5 <= 1'b0;
            d_regwrite <= 1'b0;
            d_memread  <= 1'b0;
            d_memwrite <= 1'b0;
            d_branch   <= 1'b0;
            d_jump     <= 1'b0;
            d_illegal  <= 1'b0;
        end else begin
            d_valid    <= if_valid_q;
            d_pc       <= if_pc_q;
            d_rs1      <= dec_rs1;
            d_rs2      <= dec_rs2;
            d_rd       <= dec_rd;
            d_imm      <= dec_imm;
            d_opcode   <= dec_opcode;
            d_funct3   <= if_inst_q[14:12];
            d_funct7b5 <= if_inst_q[30];
            d_regwrite <= dec_regwrite;
            d_memread  <= dec_memread;
            d_memwrite <= dec_memwrite;
            d_branch   <= dec_branch;
            d_jump     <= dec_jump;
            d_illegal  <= dec_illegal;
        end
    end

endmodule
